// File: rtl/shift_sub_divider_if.sv
// shift_sub_divider_if: start/done handshake and result bus for the sequential divider.
interface shift_sub_divider_if #(
    parameter int DIVIDEND_W = 32,
    parameter int DIVISOR_W  = 16
);
    logic                  start;
    logic [DIVIDEND_W-1:0] dividend;
    logic [DIVISOR_W-1:0]  divisor;
    logic                  busy;
    logic                  done;
    logic [DIVISOR_W-1:0]  quotient;
    logic [DIVISOR_W-1:0]  remainder;
    logic                  div_by_zero;
    logic                  overflow;
    modport master (
        output start, dividend, divisor,
        input  busy, done, quotient, remainder, div_by_zero, overflow
    );
    modport slave (
        input  start, dividend, divisor,
        output busy, done, quotient, remainder, div_by_zero, overflow
    );
endinterface

// File: rtl/shift_sub_divider.sv
// shift_sub_divider: radix-2 restoring signed/unsigned divider, one iteration per clock.
module shift_sub_divider #(
    parameter int DIVIDEND_W = 32,
    parameter int DIVISOR_W  = 16,
    parameter int SIGNED     = 1
) (
    input logic clk,
    input logic rst_n,
    shift_sub_divider_if.slave bus
);
    localparam int N  = DIVIDEND_W;
    localparam int DW = DIVISOR_W;
    localparam int CW = $clog2(N);
    localparam logic [CW-1:0] last = CW'(N - 1);
    localparam logic [N-1:0] lim_pos = N'(SIGNED != 0 ? (64'd1 << (DW - 1)) - 1 : (64'd1 << DW) - 1);
    localparam logic [N-1:0] lim_neg = N'(64'd1 << (DW - 1));
    typedef enum logic [1:0] {s_idle, s_calc, s_fix} state_t;
    state_t        state;
    logic [N-1:0]  qr;
    logic [DW-1:0] dmag;
    logic [DW:0]   rem;
    logic [CW-1:0] cnt;
    logic          qneg, rneg, dz;
    logic          sd, sv, ge, ovf_fix;
    logic [N-1:0]  dd_abs;
    logic [DW-1:0] dv_abs, q_fix, r_fix;
    logic [DW:0]   sh, diff;
    always_comb begin
        sd      = (SIGNED != 0) && bus.dividend[N-1];
        sv      = (SIGNED != 0) && bus.divisor[DW-1];
        dd_abs  = sd ? -bus.dividend : bus.dividend;
        dv_abs  = sv ? -bus.divisor : bus.divisor;
        sh      = {rem[DW-1:0], qr[N-1]};
        diff    = sh - {1'b0, dmag};
        ge      = sh >= {1'b0, dmag};
        ovf_fix = qneg ? (qr > lim_neg) : (qr > lim_pos);
        // Negative saturation bound only arises in signed mode, where it is -2^(DW-1).
        q_fix   = ovf_fix ? (qneg ? lim_neg[DW-1:0] : lim_pos[DW-1:0])
                          : (qneg ? -qr[DW-1:0] : qr[DW-1:0]);
        r_fix   = rneg ? -rem[DW-1:0] : rem[DW-1:0];
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state           <= s_idle;
            qr              <= '0;
            dmag            <= '0;
            rem             <= '0;
            cnt             <= '0;
            qneg            <= 1'b0;
            rneg            <= 1'b0;
            dz              <= 1'b0;
            bus.busy        <= 1'b0;
            bus.done        <= 1'b0;
            bus.quotient    <= '0;
            bus.remainder   <= '0;
            bus.div_by_zero <= 1'b0;
            bus.overflow    <= 1'b0;
        end else begin
            bus.done <= 1'b0;
            case (state)
                s_idle: if (bus.start) begin
                    qr       <= dd_abs;
                    dmag     <= dv_abs;
                    qneg     <= sd ^ sv;
                    rneg     <= sd;
                    rem      <= '0;
                    cnt      <= '0;
                    dz       <= bus.divisor == '0;
                    bus.busy <= 1'b1;
                    state    <= bus.divisor == '0 ? s_fix : s_calc;
                end
                s_calc: begin
                    rem   <= ge ? diff : sh;
                    qr    <= {qr[N-2:0], ge};
                    cnt   <= cnt + 1'b1;
                    state <= cnt == last ? s_fix : s_calc;
                end
                s_fix: begin
                    bus.quotient    <= dz ? '0 : q_fix;
                    bus.remainder   <= dz ? '0 : r_fix;
                    bus.div_by_zero <= dz;
                    bus.overflow    <= !dz && ovf_fix;
                    bus.done        <= 1'b1;
                    bus.busy        <= 1'b0;
                    state           <= s_idle;
                end
                default: state <= s_idle;
            endcase
        end
    end
endmodule
